// File: rtl/sram_ctrl_if.sv
// Bundle of the two requester ports and the SRAM array bus for sram_ctrl.
//   p0_*   : instruction-fetch requester (req/we/addr/wdata/be in, ack/rdata/err out)
//   p1_*   : load/store requester, same shape as p0
//   sram_* : one-hot wordline, lane write data, read enable, per-lane write enable,
//            and the array's read data coming back
// slave  : controller side.  master : requester / array side.
interface sram_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [31:0]       p0_wdata;
    logic [3:0]        p0_be;
    logic              p0_ack;
    logic [31:0]       p0_rdata;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [31:0]       p1_wdata;
    logic [3:0]        p1_be;
    logic              p1_ack;
    logic [31:0]       p1_rdata;
    logic              p1_err;

    logic [DEPTH-1:0]  sram_wordline;
    logic [31:0]       sram_datain;
    logic              sram_re;
    logic [3:0]        sram_we;
    logic [31:0]       sram_dataout;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_be,
        output p0_ack, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_be,
        output p1_ack, p1_rdata, p1_err,
        output sram_wordline, sram_datain, sram_re, sram_we,
        input  sram_dataout
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_be,
        input  p0_ack, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_be,
        input  p1_ack, p1_rdata, p1_err,
        input  sram_wordline, sram_datain, sram_re, sram_we,
        output sram_dataout
    );
endinterface

// File: rtl/sram_ctrl.sv
// Two-port sequencer for a DEPTH x 32-bit array of byte lanes.
// Round-robin arbitration between p0 (fetch) and p1 (load/store), one access
// per 5 cycles: IDLE -> ADDR -> ACT -> CAP -> DONE.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sram_ctrl_if.slave (requester ports + array bus)
// All outputs are flops loaded from the next-state decode, so they change
// only on clock edges and are clean Moore outputs.
module sram_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input logic        clk,
    input logic        rst,
    sram_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, ADDR, ACT, CAP, DONE} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
    } op_t;

    state_t           state, state_nxt;
    op_t              op, op_nxt;
    logic             grant, grant_nxt;
    logic             last_grant, last_grant_nxt;
    logic             hit, hit_nxt;
    logic [DEPTH-1:0] wordline, wordline_nxt;
    logic [31:0]      datain, datain_nxt;
    logic             re, re_nxt;
    logic [3:0]       we, we_nxt;
    logic [1:0]       ack, ack_nxt;
    logic [1:0]       err, err_nxt;
    logic [31:0]      rdata0, rdata1;

    // Address lies inside the implemented rows.
    assign hit = ({1'b0, op.addr} < DEPTH_LIM);

    always_comb begin
        state_nxt      = state;
        op_nxt         = op;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (bus.p0_req || bus.p1_req) begin
                    // On a tie the port that did not win last time goes first.
                    grant_nxt      = (bus.p0_req && bus.p1_req) ? ~last_grant : bus.p1_req;
                    last_grant_nxt = grant_nxt;
                    op_nxt         = grant_nxt ? op_t'{bus.p1_we, bus.p1_addr, bus.p1_wdata, bus.p1_be}
                                               : op_t'{bus.p0_we, bus.p0_addr, bus.p0_wdata, bus.p0_be};
                    state_nxt      = ADDR;
                end
            end
            ADDR:    state_nxt = ACT;
            ACT:     state_nxt = CAP;
            CAP:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        hit_nxt      = ({1'b0, op_nxt.addr} < DEPTH_LIM);
        wordline_nxt = '0;
        datain_nxt   = '0;
        re_nxt       = 1'b0;
        we_nxt       = '0;
        ack_nxt      = '0;
        err_nxt      = '0;

        // Wordline spans ADDR..CAP so the enables in ACT sit inside it on both sides.
        if (state_nxt == ADDR || state_nxt == ACT || state_nxt == CAP) begin
            datain_nxt = op_nxt.wdata;
            if (hit_nxt) begin
                for (int i = 0; i < DEPTH; i++)
                    wordline_nxt[i] = (op_nxt.addr == ADDR_W'(i));
            end
        end
        if (state_nxt == ACT && hit_nxt) begin
            re_nxt = ~op_nxt.we;
            we_nxt = op_nxt.we ? op_nxt.be : 4'b0000;
        end
        if (state_nxt == DONE) begin
            ack_nxt[grant_nxt] = 1'b1;
            err_nxt[grant_nxt] = ~hit_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op         <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wordline   <= '0;
            datain     <= '0;
            re         <= 1'b0;
            we         <= '0;
            ack        <= '0;
            err        <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state      <= state_nxt;
            op         <= op_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            wordline   <= wordline_nxt;
            datain     <= datain_nxt;
            re         <= re_nxt;
            we         <= we_nxt;
            ack        <= ack_nxt;
            err        <= err_nxt;
            // Array data is valid in CAP (one cycle after re). Out-of-range
            // accesses return zero; in-range writes leave rdata untouched.
            if (state == CAP && (!hit || !op.we)) begin
                if (grant) rdata1 <= hit ? bus.sram_dataout : 32'h0;
                else       rdata0 <= hit ? bus.sram_dataout : 32'h0;
            end
        end
    end

    assign bus.sram_wordline = wordline;
    assign bus.sram_datain   = datain;
    assign bus.sram_re       = re;
    assign bus.sram_we       = we;
    assign bus.p0_ack        = ack[0];
    assign bus.p1_ack        = ack[1];
    assign bus.p0_err        = err[0];
    assign bus.p1_err        = err[1];
    assign bus.p0_rdata      = rdata0;
    assign bus.p1_rdata      = rdata1;
endmodule
